// File: rtl/queue_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | queue_serializer: dequeues bytes from the slow-domain queue and    |
// | shifts them out MSB first with a per-bit write strobe.             |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module queue_serializer #(
  parameter int BIT_DIV     = 10,
  parameter int DEQ_TIMEOUT = 1023
) (
  input  logic       clk,
  input  logic       queue_rst,
  input  logic [3:0] queue_len_in,
  input  logic [7:0] queue_data_in,
  input  logic       ready_in,
  output logic       queue_dequeue_out,
  output logic       serial_data_out,
  output logic       serial_write_out,
  output logic       byte_done_out,
  output logic       busy_out,
  output logic       error_out
);

  localparam int DW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam int TW = $clog2(DEQ_TIMEOUT + 1);
  localparam logic [DW-1:0] c_DIV_LAST = DW'(BIT_DIV - 1);
  localparam logic [TW-1:0] c_TMO_LAST = TW'(DEQ_TIMEOUT - 1);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_DEQ   = 3'd1;
  localparam logic [2:0] c_LOAD  = 3'd2;
  localparam logic [2:0] c_SHIFT = 3'd3;
  localparam logic [2:0] c_GAP   = 3'd4;

  logic [3:0]    r_len_s1, r_len_s2, r_len_s3;
  logic [7:0]    r_dat_s1, r_dat_s2, r_dat_s3;
  logic [2:0]    r_state;
  logic [3:0]    r_len_ref;
  logic [TW-1:0] r_tmo;
  logic [DW-1:0] r_div;
  logic [3:0]    r_bitcnt;
  logic [7:0]    r_shreg;
  logic          r_byte_done;
  logic          r_error;

  logic          w_len_ok;
  logic          w_dat_ok;
  logic [3:0]    w_bit_next;

  // Third stage only serves the "two consecutive samples agree" test.
  always_ff @(posedge clk or posedge queue_rst) begin
    if (queue_rst) begin
      r_len_s1 <= '0;
      r_len_s2 <= '0;
      r_len_s3 <= '0;
      r_dat_s1 <= '0;
      r_dat_s2 <= '0;
      r_dat_s3 <= '0;
    end else begin
      r_len_s1 <= queue_len_in;
      r_len_s2 <= r_len_s1;
      r_len_s3 <= r_len_s2;
      r_dat_s1 <= queue_data_in;
      r_dat_s2 <= r_dat_s1;
      r_dat_s3 <= r_dat_s2;
    end
  end

  assign w_len_ok   = (r_len_s2 == r_len_s3);
  assign w_dat_ok   = (r_dat_s2 == r_dat_s3);
  assign w_bit_next = r_bitcnt + 4'd1;

  always_ff @(posedge clk or posedge queue_rst) begin
    if (queue_rst) begin
      r_state     <= c_IDLE;
      r_len_ref   <= '0;
      r_tmo       <= '0;
      r_div       <= '0;
      r_bitcnt    <= '0;
      r_shreg     <= '0;
      r_byte_done <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_byte_done <= 1'b0;
      r_error     <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (w_len_ok && (r_len_s3 != 4'd0) && ready_in) begin
            r_len_ref <= r_len_s3;
            r_tmo     <= '0;
            r_state   <= c_DEQ;
          end
        end
        c_DEQ: begin
          if (w_len_ok && (r_len_s3 < r_len_ref)) begin
            r_state <= c_LOAD;
          end else if (w_len_ok && (r_len_s3 > r_len_ref)) begin
            r_len_ref <= r_len_s3;
            r_tmo     <= r_tmo + 1'b1;
          end else if (r_tmo == c_TMO_LAST) begin
            r_error <= 1'b1;
            r_state <= c_IDLE;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        c_LOAD: begin
          if (w_dat_ok) begin
            r_shreg  <= r_dat_s3;
            r_bitcnt <= '0;
            r_div    <= '0;
            r_state  <= c_SHIFT;
          end
        end
        c_SHIFT: begin
          if (r_div == c_DIV_LAST) begin
            r_div    <= '0;
            r_shreg  <= {r_shreg[6:0], 1'b0};
            r_bitcnt <= w_bit_next;
            if (w_bit_next[3]) begin
              r_byte_done <= 1'b1;
              r_state     <= c_GAP;
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        c_GAP: begin
          if (r_div == c_DIV_LAST) begin
            r_div   <= '0;
            r_state <= c_IDLE;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign queue_dequeue_out = (r_state == c_DEQ);
  assign serial_write_out  = (r_state == c_SHIFT);
  assign serial_data_out   = (r_state == c_SHIFT) & r_shreg[7];
  assign busy_out          = (r_state != c_IDLE);
  assign byte_done_out     = r_byte_done;
  assign error_out         = r_error;

endmodule
`default_nettype wire

// File: tb/tb_queue_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_queue_serializer: queue emulator + frame monitor bench.         |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_queue_serializer;

  localparam int BD  = 10;
  localparam int TMO = 1023;

  logic       clk = 1'b0;
  logic       queue_rst;
  logic [3:0] queue_len_in;
  logic [7:0] queue_data_in;
  logic       ready_in;
  logic       queue_dequeue_out;
  logic       serial_data_out;
  logic       serial_write_out;
  logic       byte_done_out;
  logic       busy_out;
  logic       error_out;

  always #5 clk = ~clk;

  queue_serializer #(.BIT_DIV(BD), .DEQ_TIMEOUT(TMO)) dut (
    .clk               (clk),
    .queue_rst         (queue_rst),
    .queue_len_in      (queue_len_in),
    .queue_data_in     (queue_data_in),
    .ready_in          (ready_in),
    .queue_dequeue_out (queue_dequeue_out),
    .serial_data_out   (serial_data_out),
    .serial_write_out  (serial_write_out),
    .byte_done_out     (byte_done_out),
    .busy_out          (busy_out),
    .error_out         (error_out)
  );

  int         total, bad, cyc;
  logic [7:0] q[$];
  logic [7:0] exp_q[$];
  logic [7:0] frames[$];
  int         flens[$];
  int         fstart[$];
  bit         fok[$];
  bit         bits[$];
  int         run, wend, done_cyc, idle_cyc, done_cnt, err_cnt, deq_cycles;
  bit         prev_busy, served, auto_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: monitor the serial link, then play the queue's side.
  task automatic tick();
    logic [7:0] b;
    bit         ok;
    @(negedge clk);
    cyc++;
    if (serial_write_out) begin
      if (run == 0) fstart.push_back(cyc);
      bits.push_back(serial_data_out);
      run++;
    end else if (run != 0) begin
      b  = 8'h00;
      ok = 1'b1;
      for (int k = 0; k < 8; k++)
        b = {b[6:0], (k * BD < bits.size()) ? bits[k * BD] : 1'b0};
      for (int i = 0; i < bits.size(); i++)
        if (bits[i] != bits[(i / BD) * BD]) ok = 1'b0;
      frames.push_back(b);
      flens.push_back(run);
      fok.push_back(ok);
      wend = cyc - 1;
      bits.delete();
      run = 0;
    end
    if (byte_done_out) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (error_out) err_cnt++;
    if (queue_dequeue_out) deq_cycles++;
    if (prev_busy && !busy_out) idle_cyc = cyc;
    prev_busy = busy_out;
    if (auto_q) begin
      if (queue_dequeue_out && !served && q.size() > 0) begin
        queue_data_in = q.pop_front();
        served = 1'b1;
      end
      if (!queue_dequeue_out) served = 1'b0;
      queue_len_in = 4'(q.size());
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_frames(input int n, input int limit);
    int k;
    k = 0;
    while (frames.size() < n && k < limit) begin
      tick();
      k++;
    end
    chk("frame_wait", 32'(frames.size() >= n), 1);
  endtask

  task automatic push(input logic [7:0] v);
    q.push_back(v);
    exp_q.push_back(v);
  endtask

  initial begin
    int n, base, d0, e0;
    total = 0; bad = 0; cyc = 0; run = 0; wend = 0; done_cyc = 0; idle_cyc = 0;
    done_cnt = 0; err_cnt = 0; deq_cycles = 0;
    prev_busy = 0; served = 0; auto_q = 0;
    queue_rst = 1'b1; queue_len_in = 4'd0; queue_data_in = 8'd0; ready_in = 1'b0;

    // Reset state
    ticks(3);
    chk("rst_deq",  queue_dequeue_out, 0);
    chk("rst_data", serial_data_out, 0);
    chk("rst_wr",   serial_write_out, 0);
    chk("rst_done", byte_done_out, 0);
    chk("rst_busy", busy_out, 0);
    chk("rst_err",  error_out, 0);
    queue_rst = 1'b0;
    auto_q = 1'b1;

    // Empty queue stays idle even when ready
    ready_in = 1'b1;
    ticks(50);
    chk("empty_deq",  deq_cycles, 0);
    chk("empty_busy", busy_out, 0);

    // Single byte 0xA5
    push(8'hA5);
    wait_frames(1, 300);
    ticks(15);
    chk("single_byte", frames[0], exp_q[0]);
    chk("single_len",  flens[0], 8 * BD);
    chk("single_hold", fok[0], 1);
    chk("single_done_cnt", done_cnt, 1);
    chk("single_done_at_gap", done_cyc - wend, 1);
    chk("single_gap_len", idle_cyc - wend, BD + 1);
    chk("single_busy_end", busy_out, 0);

    // Ready gating
    ready_in = 1'b0;
    d0 = deq_cycles;
    push(8'($urandom));
    push(8'($urandom));
    ticks(500);
    chk("gate_no_deq", deq_cycles - d0, 0);
    chk("gate_busy", busy_out, 0);
    ready_in = 1'b1;
    n = 0;
    while (!queue_dequeue_out && n < 5) begin
      tick();
      n++;
    end
    chk("gate_start_2cyc", 32'(n <= 2), 1);
    wait_frames(3, 600);

    // Random stream with enqueues during transmission
    for (int i = 0; i < 3; i++) push(8'($urandom));
    ticks($urandom_range(0, 200));
    for (int i = 0; i < 3; i++) push(8'($urandom));
    wait_frames(9, 2500);
    for (int i = 1; i < 9; i++) begin
      chk("stream_byte", frames[i], exp_q[i]);
      chk("stream_len",  flens[i], 8 * BD);
      chk("stream_hold", fok[i], 1);
      chk("stream_spacing", 32'(fstart[i] - fstart[i-1] >= 9 * BD), 1);
    end
    ticks(20);

    // Dequeue timeout: length never drops
    auto_q = 1'b0;
    ready_in = 1'b0;
    queue_len_in = 4'd3;
    ticks(10);
    e0 = err_cnt;
    ready_in = 1'b1;
    n = 0;
    while (!queue_dequeue_out && n < 6) begin
      tick();
      n++;
    end
    n = 0;
    while (queue_dequeue_out && n < TMO + 100) begin
      n++;
      tick();
    end
    ready_in = 1'b0;
    chk("tmo_deq_cycles", n, TMO);
    chk("tmo_err_pulse", error_out, 1);
    chk("tmo_idle", busy_out, 0);
    ticks(20);
    chk("tmo_err_once", err_cnt - e0, 1);
    chk("tmo_stay_idle", queue_dequeue_out, 0);

    // Concurrent enqueue while in DEQ
    base = frames.size();
    queue_data_in = 8'h5A;
    queue_len_in = 4'd2;
    ticks(10);
    ready_in = 1'b1;
    n = 0;
    while (!queue_dequeue_out && n < 6) begin
      tick();
      n++;
    end
    queue_len_in = 4'd3;
    ticks(10);
    chk("cc_still_deq", queue_dequeue_out, 1);
    queue_len_in = 4'd2;
    n = 0;
    while (queue_dequeue_out && n < 10) begin
      tick();
      n++;
    end
    ready_in = 1'b0;
    chk("cc_load_latency", n, 4);
    wait_frames(base + 1, 200);
    chk("cc_byte", frames[base], 8'h5A);
    ticks(20);

    // Reset during bit 4 of 0x81
    auto_q = 1'b1;
    ticks(10);
    base = frames.size();
    push(8'h81);
    ready_in = 1'b1;
    n = 0;
    while (!serial_write_out && n < 50) begin
      tick();
      n++;
    end
    ticks(4 * BD + 3);
    chk("mid_writing", serial_write_out, 1);
    chk("mid_bit4", serial_data_out, 0);
    queue_rst = 1'b1;
    #1;
    chk("mid_rst_wr",   serial_write_out, 0);
    chk("mid_rst_busy", busy_out, 0);
    chk("mid_rst_deq",  queue_dequeue_out, 0);
    chk("mid_rst_data", serial_data_out, 0);
    bits.delete();
    run = 0;
    void'(exp_q.pop_back());
    ticks(3);
    queue_rst = 1'b0;
    ticks(30);
    chk("post_rst_idle", busy_out, 0);
    chk("post_rst_nothing", frames.size(), base);
    push(8'h42);
    wait_frames(base + 1, 300);
    chk("post_rst_byte", frames[base], 8'h42);
    ticks(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/queue_serializer.md
# queue_serializer

Transmit-side counterpart of the deserializer path. Pulls bytes out of the 8-entry queue with a dequeue handshake, then shifts each byte out as a serial bit stream with a per-bit write strobe, formatted for a downstream deserializer. Sits between the queue outputs (`len_out`/`data_out`, slow 10 kHz domain) and the serial link. Runs entirely on the 1 MHz `clk` and generates its bit timing with clock enables.

## Interface

- `BIT_DIV`, default 10: `clk` cycles per serial bit, giving 100 kbit/s at 1 MHz. Legal values are ≥ 2.
- `DEQ_TIMEOUT`, default 1023: maximum `clk` cycles spent in DEQ before the block aborts.
- `clk`  in  1  system clock, 1 MHz.
- `queue_rst`  in  1  asynchronous, active-high reset.
- `queue_len_in`  in  4  queue element count (0–8), from the slow domain.
- `queue_data_in`  in  8  byte removed by the queue, from the slow domain.
- `ready_in`  in  1  downstream status: 1 = available, 0 = busy.
- `queue_dequeue_out`  out  1  dequeue request to the queue.
- `serial_data_out`  out  1  serial bit, MSB first.
- `serial_write_out`  out  1  bit-valid strobe, held for the whole bit time.
- `byte_done_out`  out  1  one-cycle pulse after the last bit of a byte.
- `busy_out`  out  1  high whenever the state is not IDLE.
- `error_out`  out  1  one-cycle pulse on dequeue timeout.

## Operation

- **Input synchronization.** `queue_len_in` and `queue_data_in` each pass through a 2-flop synchronizer.
  - A synchronized value is "settled" only when two consecutive samples agree.
  - All decisions below use settled values only.
- **IDLE.**
  - Move to DEQ when settled len ≠ 0 and `ready_in` = 1.
  - On entry to DEQ, record `len_ref` = settled len and clear the timeout counter.
- **DEQ.**
  - `queue_dequeue_out` = 1.
  - If settled len < `len_ref`: the dequeue is confirmed; go to LOAD.
  - If settled len > `len_ref` (concurrent enqueue): update `len_ref` to the new value and keep waiting.
  - If the timeout counter reaches `DEQ_TIMEOUT`: pulse `error_out`, go to IDLE, no byte is sent.
- **LOAD.**
  - `queue_dequeue_out` = 0.
  - Wait for settled data. Capture it into an 8-bit shift register and set bit count = 0.
  - Go to SHIFT with the divider cleared.
- **SHIFT.**
  - `serial_write_out` = 1 and `serial_data_out` = shreg[7].
  - The divider counts 0..`BIT_DIV`−1. At `BIT_DIV`−1: shift left by one and increment bit count.
  - After bit 7 completes: pulse `byte_done_out` and go to GAP.
- **GAP.**
  - Lasts one bit time (`BIT_DIV` cycles).
  - `serial_write_out` = 0 and `serial_data_out` = 0.
  - Then return to IDLE.
- **`ready_in` handling.** `ready_in` is checked only in IDLE. Once a byte has started, it is always completed.
- **Width rules.**
  - Bit count is 3 bits plus an end flag.
  - The divider is $clog2(`BIT_DIV`) bits wide.
  - The timeout counter is 10 bits wide (sized from `DEQ_TIMEOUT`).
  - `len` comparisons are unsigned, 4 bits.

## Timing

- **Reset.**
  - Every output = 0, state = IDLE, shift register = 0, all counters = 0.
  - `len_ref` = 0 and the synchronizers are cleared.
- **Reset mid-operation.** Outputs drop to 0 immediately (asynchronous). A partially sent byte is lost and not resent.
- **Latencies.**
  - Settled len to `queue_dequeue_out` high: 1 cycle.
  - Input change to settled: 3 cycles.
  - Confirmed len decrement to first valid bit: LOAD settle time (2 cycles when data is already stable) + 1 cycle.
- **Byte timing.**
  - One byte occupies exactly 8·`BIT_DIV` cycles with `serial_write_out` high.
  - This is followed by `BIT_DIV` cycles of gap.
- **Strobes.**
  - `byte_done_out` is asserted on the first GAP cycle.
  - `error_out` is asserted on the cycle DEQ exits to IDLE.
- **Back-to-back.** With the queue non-empty and `ready_in` high, minimum byte-to-byte spacing is 9·`BIT_DIV` cycles plus the DEQ/LOAD time.
- **Empty queue.** Settled len = 0 keeps the block in IDLE; `queue_dequeue_out` never asserts.
- **Simultaneous enqueue + dequeue.** Net len may be unchanged. DEQ waits and either sees the later decrement or times out.

## Test plan

- **Single byte.** Queue len 0→1 with data 0xA5, `ready_in` = 1 → dequeue asserted, then serial 1,0,1,0,0,1,0,1. Each bit is held 10 cycles with write = 1, `byte_done_out` pulses once, and `busy_out` returns to 0.
- **Ready gating.** len = 2, `ready_in` = 0 for 500 cycles → no dequeue and `busy_out` = 0. Then `ready_in` = 1 → the byte starts within 2 cycles.
- **Timeout.** len held at 3 with no decrement → `queue_dequeue_out` is high for 1023 cycles, then `error_out` pulses and the block returns to IDLE.
- **Two bytes.** Two queued bytes 0x3C and 0xFF → frames are sent in order. The second frame starts no earlier than 90 cycles after the first frame starts.
- **Reset mid-byte.** Assert `queue_rst` during bit 4 of 0x81 → all outputs go to 0 in the same cycle. After release the block is in IDLE with settled len re-evaluated.
- **Concurrent enqueue.** In DEQ with `len_ref` = 2, len goes 2→3→2 → the block stays in DEQ after the increase, then LOAD on the decrement to 2.
